// File: rtl/analog_intl_pkg.sv
// Shared fault bit map and float32 ordering helpers for the analog interlock detector.
// Pure combinational functions; no state, no flow control.
package analog_intl_pkg;
    localparam int FLT_NUM       = 11;
    localparam int FLT_C_OVER    = 0;
    localparam int FLT_V_OVER    = 1;
    localparam int FLT_DC_C_OVER = 2;
    localparam int FLT_DC_V_OVER = 3;
    localparam int FLT_IGBT_T    = 4;
    localparam int FLT_I_ID_T    = 5;
    localparam int FLT_O_ID_T    = 6;
    localparam int FLT_C_WINDOW  = 7;
    localparam int FLT_V_WINDOW  = 8;
    localparam int FLT_PH_UNDER  = 9;
    localparam int FLT_PH_OVER   = 10;

    function automatic logic flt_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps float32 onto an unsigned key with the same ordering; -0 folds onto +0.
    function automatic logic [31:0] flt_key(input logic [31:0] x);
        logic [31:0] n;
        n = (x == 32'h8000_0000) ? 32'h0 : x;
        return n[31] ? ~n : {1'b1, n[30:0]};
    endfunction

    function automatic logic [31:0] flt_abs(input logic [31:0] x);
        return {1'b0, x[30:0]};
    endfunction

    // Strict a > b; any NaN operand reports true so a broken value trips.
    function automatic logic flt_gt(input logic [31:0] a, input logic [31:0] b);
        return flt_is_nan(a) || flt_is_nan(b) || (flt_key(a) > flt_key(b));
    endfunction
endpackage

// File: rtl/analog_intl_window.sv
// Windowed fluctuation detector: counts hit samples per window and trips after N qualifying windows in a row.
// Trip is combinational on the strobe cycle; counters update on the same edge. No backpressure.
module analog_intl_window
    import analog_intl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 meas_valid,
    input  logic [31:0]          meas,
    input  logic [31:0]          data_thresh,
    input  logic [CNT_WIDTH-1:0] cnt_thresh,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic                 trip
);
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] smp_cnt, hit_cnt, run_cnt;
    logic [CNT_WIDTH-1:0] hit_nxt, run_nxt, run_min;
    logic                 active, hit, win_end, qualify;

    always_comb begin
        active  = (period != '0);
        hit     = flt_gt(flt_abs(meas), data_thresh);
        hit_nxt = (hit && hit_cnt != MAX) ? hit_cnt + ONE : hit_cnt;
        // >= rather than == so a live period reduction closes the window at once
        win_end = (smp_cnt >= period - ONE);
        qualify = (hit_nxt >= cnt_thresh);
        run_nxt = qualify ? ((run_cnt != MAX) ? run_cnt + ONE : run_cnt) : '0;
        run_min = (cycle_cnt == '0) ? ONE : cycle_cnt;
        trip    = meas_valid && active && win_end && qualify && (run_nxt >= run_min);
    end

    always_ff @(posedge clk) begin
        if (rst || clr || !active) begin
            smp_cnt <= '0;
            hit_cnt <= '0;
            run_cnt <= '0;
        end else if (meas_valid) begin
            if (win_end) begin
                smp_cnt <= '0;
                hit_cnt <= '0;
                run_cnt <= run_nxt;
            end else begin
                smp_cnt <= smp_cnt + ONE;
                hit_cnt <= hit_nxt;
            end
        end
    end
endmodule

// File: rtl/analog_intl_detect.sv
// Compares live float32 ADC measurements with interlock setpoints and latches per-channel faults until cleared.
// Faults appear one cycle after the measurement strobe; no backpressure, every strobe is evaluated.
module analog_intl_detect
    import analog_intl_pkg::*;
#(
    parameter int C_CNT_WIDTH = 32,
    parameter int C_FLT_NUM   = FLT_NUM
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_meas_valid,
    input  logic [31:0]            i_c_meas,
    input  logic [31:0]            i_v_meas,
    input  logic [31:0]            i_dc_c_meas,
    input  logic [31:0]            i_dc_v_meas,
    input  logic [31:0]            i_igbt_t_meas,
    input  logic [31:0]            i_i_id_t_meas,
    input  logic [31:0]            i_o_id_t_meas,
    input  logic [31:0]            i_phase_meas,
    input  logic [31:0]            i_c_over_sp,
    input  logic [31:0]            i_v_over_sp,
    input  logic [31:0]            i_dc_c_over_sp,
    input  logic [31:0]            i_dc_v_over_sp,
    input  logic [31:0]            i_igbt_t_over_sp,
    input  logic [31:0]            i_i_id_t_over_sp,
    input  logic [31:0]            i_o_id_t_over_sp,
    input  logic [31:0]            i_c_data_thresh,
    input  logic [31:0]            i_v_data_thresh,
    input  logic [C_CNT_WIDTH-1:0] i_c_cnt_thresh,
    input  logic [C_CNT_WIDTH-1:0] i_v_cnt_thresh,
    input  logic [C_CNT_WIDTH-1:0] i_c_period,
    input  logic [C_CNT_WIDTH-1:0] i_v_period,
    input  logic [C_CNT_WIDTH-1:0] i_c_cycle_cnt,
    input  logic [C_CNT_WIDTH-1:0] i_v_cycle_cnt,
    input  logic [31:0]            i_phase_under_data,
    input  logic [31:0]            i_phase_over_data,
    input  logic                   i_intl_clr,
    input  logic [C_FLT_NUM-1:0]   i_intl_mask,
    output logic [C_FLT_NUM-1:0]   o_fault,
    output logic [C_FLT_NUM-1:0]   o_first_fault,
    output logic                   o_intl
);
    logic                 c_trip, v_trip;
    logic [C_FLT_NUM-1:0] cond, set, fault_nxt;

    analog_intl_window #(.CNT_WIDTH(C_CNT_WIDTH)) u_c_window (
        .clk(i_clk), .rst(i_rst), .clr(i_intl_clr), .meas_valid(i_meas_valid),
        .meas(i_c_meas), .data_thresh(i_c_data_thresh), .cnt_thresh(i_c_cnt_thresh),
        .period(i_c_period), .cycle_cnt(i_c_cycle_cnt), .trip(c_trip)
    );

    analog_intl_window #(.CNT_WIDTH(C_CNT_WIDTH)) u_v_window (
        .clk(i_clk), .rst(i_rst), .clr(i_intl_clr), .meas_valid(i_meas_valid),
        .meas(i_v_meas), .data_thresh(i_v_data_thresh), .cnt_thresh(i_v_cnt_thresh),
        .period(i_v_period), .cycle_cnt(i_v_cycle_cnt), .trip(v_trip)
    );

    always_comb begin
        cond = '0;
        cond[FLT_C_OVER]    = flt_gt(flt_abs(i_c_meas), i_c_over_sp);
        cond[FLT_V_OVER]    = flt_gt(flt_abs(i_v_meas), i_v_over_sp);
        cond[FLT_DC_C_OVER] = flt_gt(flt_abs(i_dc_c_meas), i_dc_c_over_sp);
        cond[FLT_DC_V_OVER] = flt_gt(flt_abs(i_dc_v_meas), i_dc_v_over_sp);
        // Temperatures keep their sign: a deep negative reading is not over-limit.
        cond[FLT_IGBT_T]    = flt_gt(i_igbt_t_meas, i_igbt_t_over_sp);
        cond[FLT_I_ID_T]    = flt_gt(i_i_id_t_meas, i_i_id_t_over_sp);
        cond[FLT_O_ID_T]    = flt_gt(i_o_id_t_meas, i_o_id_t_over_sp);
        cond[FLT_C_WINDOW]  = c_trip;
        cond[FLT_V_WINDOW]  = v_trip;
        cond[FLT_PH_UNDER]  = flt_gt(i_phase_under_data, i_phase_meas);
        cond[FLT_PH_OVER]   = flt_gt(i_phase_meas, i_phase_over_data);
        set       = i_meas_valid ? (cond & ~i_intl_mask) : '0;
        fault_nxt = (o_fault & ~{C_FLT_NUM{i_intl_clr}}) | set;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fault       <= '0;
            o_first_fault <= '0;
            o_intl        <= 1'b0;
        end else begin
            o_fault <= fault_nxt;
            o_intl  <= |fault_nxt;
            // A set coinciding with a clear starts a fresh first-fault record.
            if ((|set) && (o_fault == '0 || i_intl_clr))
                o_first_fault <= set;
            else if (i_intl_clr)
                o_first_fault <= '0;
        end
    end
endmodule

// File: tb/tb_analog_intl_detect.sv
// Scoreboard bench for analog_intl_detect: expected outputs queued at each drive, compared one edge later.
module tb_analog_intl_detect;
    localparam logic [31:0] F_0    = 32'h0000_0000;
    localparam logic [31:0] F_NEG0 = 32'h8000_0000;
    localparam logic [31:0] F_TINY = 32'h0000_0001;
    localparam logic [31:0] F_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] F_10   = 32'h4120_0000;
    localparam logic [31:0] F_50   = 32'h4248_0000;
    localparam logic [31:0] F_60   = 32'h4270_0000;
    localparam logic [31:0] F_N60  = 32'hC270_0000;
    localparam logic [31:0] F_100  = 32'h42C8_0000;
    localparam logic [31:0] F_150  = 32'h4316_0000;
    localparam logic [31:0] F_N150 = 32'hC316_0000;
    localparam logic [31:0] F_180  = 32'h4334_0000;
    localparam logic [31:0] F_198  = 32'h4346_0000;
    localparam logic [31:0] F_220  = 32'h435C_0000;
    localparam logic [31:0] F_242  = 32'h4372_0000;
    localparam logic [31:0] F_250  = 32'h437A_0000;
    localparam logic [31:0] F_1000 = 32'h447A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        meas_valid, intl_clr;
    logic [31:0] c_meas, v_meas, dc_c_meas, dc_v_meas;
    logic [31:0] igbt_t_meas, i_id_t_meas, o_id_t_meas, phase_meas;
    logic [31:0] c_over_sp, v_over_sp, dc_c_over_sp, dc_v_over_sp;
    logic [31:0] igbt_t_over_sp, i_id_t_over_sp, o_id_t_over_sp;
    logic [31:0] c_data_thresh, v_data_thresh, phase_under, phase_over;
    logic [31:0] c_cnt_thresh, v_cnt_thresh, c_period, v_period, c_cycle_cnt, v_cycle_cnt;
    logic [10:0] intl_mask;
    logic [10:0] fault, first_fault;
    logic        intl;

    typedef struct packed {
        logic [10:0] fault;
        logic [10:0] first;
        logic        intl;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    analog_intl_detect dut (
        .i_clk(clk), .i_rst(rst), .i_meas_valid(meas_valid),
        .i_c_meas(c_meas), .i_v_meas(v_meas), .i_dc_c_meas(dc_c_meas), .i_dc_v_meas(dc_v_meas),
        .i_igbt_t_meas(igbt_t_meas), .i_i_id_t_meas(i_id_t_meas), .i_o_id_t_meas(o_id_t_meas),
        .i_phase_meas(phase_meas),
        .i_c_over_sp(c_over_sp), .i_v_over_sp(v_over_sp),
        .i_dc_c_over_sp(dc_c_over_sp), .i_dc_v_over_sp(dc_v_over_sp),
        .i_igbt_t_over_sp(igbt_t_over_sp), .i_i_id_t_over_sp(i_id_t_over_sp),
        .i_o_id_t_over_sp(o_id_t_over_sp),
        .i_c_data_thresh(c_data_thresh), .i_v_data_thresh(v_data_thresh),
        .i_c_cnt_thresh(c_cnt_thresh), .i_v_cnt_thresh(v_cnt_thresh),
        .i_c_period(c_period), .i_v_period(v_period),
        .i_c_cycle_cnt(c_cycle_cnt), .i_v_cycle_cnt(v_cycle_cnt),
        .i_phase_under_data(phase_under), .i_phase_over_data(phase_over),
        .i_intl_clr(intl_clr), .i_intl_mask(intl_mask),
        .o_fault(fault), .o_first_fault(first_fault), .o_intl(intl)
    );

    task automatic check(input string tag, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: drive strobe/clear, queue the expectation, compare just after the edge.
    task automatic step(input string tag, input logic vld, input logic clr,
                        input logic [10:0] ef, input logic [10:0] efirst);
        exp_t e;
        @(negedge clk);
        meas_valid = vld;
        intl_clr   = clr;
        e.fault = ef;
        e.first = efirst;
        e.intl  = |ef;
        sb.push_back(e);
        @(posedge clk);
        #1;
        meas_valid = 1'b0;
        intl_clr   = 1'b0;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 11'h1, 11'h0);
        end else begin
            e = sb.pop_front();
            check({tag, ".fault"}, fault, e.fault);
            check({tag, ".first"}, first_fault, e.first);
            check({tag, ".intl"}, {10'b0, intl}, {10'b0, e.intl});
        end
    endtask

    // Four-sample c-window; pat[k]=1 means sample k exceeds the 50.0 hit level.
    task automatic win(input string tag, input logic [3:0] pat,
                       input logic [10:0] bf, input logic [10:0] bfirst,
                       input logic [10:0] endf, input logic [10:0] endfirst);
        for (int k = 0; k < 4; k++) begin
            c_meas = pat[k] ? ((k % 2 == 1) ? F_N60 : F_60) : F_10;
            if (k == 3) step(tag, 1'b1, 1'b0, endf, endfirst);
            else        step(tag, 1'b1, 1'b0, bf, bfirst);
        end
    endtask

    initial begin
        rst = 1'b1; meas_valid = 1'b0; intl_clr = 1'b0; intl_mask = '0;
        c_meas = F_0; v_meas = F_0; dc_c_meas = F_0; dc_v_meas = F_0;
        igbt_t_meas = F_0; i_id_t_meas = F_0; o_id_t_meas = F_0; phase_meas = F_220;
        c_over_sp = F_100; v_over_sp = F_1000; dc_c_over_sp = F_1000; dc_v_over_sp = F_1000;
        igbt_t_over_sp = F_100; i_id_t_over_sp = F_1000; o_id_t_over_sp = F_1000;
        c_data_thresh = F_50; v_data_thresh = F_50; phase_under = F_198; phase_over = F_242;
        c_cnt_thresh = 32'd2; v_cnt_thresh = 32'd0; c_period = 32'd0; v_period = 32'd0;
        c_cycle_cnt = 32'd3; v_cycle_cnt = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.fault", fault, 11'h000);
        check("reset.first", first_fault, 11'h000);
        check("reset.intl", {10'b0, intl}, 11'h000);
        rst = 1'b0;

        // Over-limit on |current|, equality, NaN, signed zero
        c_meas = F_N150;
        step("no_strobe", 1'b0, 1'b0, 11'h000, 11'h000);
        step("c_over_neg", 1'b1, 1'b0, 11'h001, 11'h001);
        step("clr1", 1'b0, 1'b1, 11'h000, 11'h000);
        c_meas = F_100;
        step("c_equal", 1'b1, 1'b0, 11'h000, 11'h000);
        c_meas = F_NAN;
        step("c_nan", 1'b1, 1'b0, 11'h001, 11'h001);
        c_meas = F_0;
        step("clr2", 1'b0, 1'b1, 11'h000, 11'h000);
        c_over_sp = F_NEG0;
        step("neg_zero_eq", 1'b1, 1'b0, 11'h000, 11'h000);
        c_meas = F_TINY;
        step("tiny_over_nz", 1'b1, 1'b0, 11'h001, 11'h001);
        c_meas = F_0; c_over_sp = F_100;
        step("clr3", 1'b0, 1'b1, 11'h000, 11'h000);

        // Phase window, and clear colliding with a new set
        step("phase_in", 1'b1, 1'b0, 11'h000, 11'h000);
        phase_meas = F_242;
        step("phase_eq_over", 1'b1, 1'b0, 11'h000, 11'h000);
        phase_meas = F_250;
        step("phase_over", 1'b1, 1'b0, 11'h400, 11'h400);
        step("phase_over_clr", 1'b1, 1'b1, 11'h400, 11'h400);
        phase_meas = F_180;
        step("phase_under_clr", 1'b1, 1'b1, 11'h200, 11'h200);
        phase_meas = F_220;
        step("clr4", 1'b0, 1'b1, 11'h000, 11'h000);

        // Signed temperature, masking, first-fault ordering
        igbt_t_meas = F_N150;
        step("igbt_neg", 1'b1, 1'b0, 11'h000, 11'h000);
        igbt_t_meas = F_150; intl_mask = 11'h010;
        step("igbt_masked", 1'b1, 1'b0, 11'h000, 11'h000);
        intl_mask = 11'h000;
        step("igbt_unmask", 1'b1, 1'b0, 11'h010, 11'h010);
        igbt_t_meas = F_0; c_meas = F_N150;
        step("second_fault", 1'b1, 1'b0, 11'h011, 11'h010);
        c_meas = F_0;
        step("clr5", 1'b0, 1'b1, 11'h000, 11'h000);

        // Window detector disabled by period 0
        c_meas = F_60;
        for (int n = 0; n < 100; n++) step("period0", 1'b1, 1'b0, 11'h000, 11'h000);

        // Window detector: period 4, 2 hits, 3 windows
        c_period = 32'd4;
        win("w1", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w2", 4'b1010, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w3_one_hit", 4'b0001, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w4", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w5", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w6_trip", 4'b0011, 11'h000, 11'h000, 11'h080, 11'h080);
        step("clr6", 1'b0, 1'b1, 11'h000, 11'h000);
        intl_mask = 11'h080;
        win("w7", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w8", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w9_masked", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        intl_mask = 11'h000;
        win("w10_retrip", 4'b0011, 11'h000, 11'h000, 11'h080, 11'h080);
        step("clr7", 1'b0, 1'b1, 11'h000, 11'h000);

        // Reset mid-window discards partial window and run count
        win("w11", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w12", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        c_meas = F_60;
        step("partial", 1'b1, 1'b0, 11'h000, 11'h000);
        step("partial", 1'b1, 1'b0, 11'h000, 11'h000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.fault", fault, 11'h000);
        check("midrst.intl", {10'b0, intl}, 11'h000);
        win("w13", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w14", 4'b0011, 11'h000, 11'h000, 11'h000, 11'h000);
        win("w15_trip", 4'b0011, 11'h000, 11'h000, 11'h080, 11'h080);

        check("sb_drained", 11'(sb.size()), 11'h000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
